// File: rtl/cmos_pixel_capture_if.sv
// Sensor-side and pixel-side signal bundle for cmos_pixel_capture.
// slave: the capture block; master: the sensor/consumer side.
interface cmos_pixel_capture_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned XW = 12,
    parameter int unsigned YW = 12
);
    logic              cmos_vsync;
    logic              cmos_href;
    logic [DW-1:0]     cmos_d;
    logic [1:0]        mode;
    logic              enable;
    logic [2*DW-1:0]   pix_data;
    logic              pix_valid;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic              frame_start;
    logic              frame_end;
    logic [15:0]       frame_cnt;
    logic              line_err;

    modport slave (
        input  cmos_vsync, cmos_href, cmos_d, mode, enable,
        output pix_data, pix_valid, pix_x, pix_y,
               frame_start, frame_end, frame_cnt, line_err
    );

    modport master (
        output cmos_vsync, cmos_href, cmos_d, mode, enable,
        input  pix_data, pix_valid, pix_x, pix_y,
               frame_start, frame_end, frame_cnt, line_err
    );
endinterface

// File: rtl/cmos_pixel_capture.sv
// CMOS sensor byte stream to pixel assembler with dummy-frame skip,
// per-frame enable, coordinates, frame counting and odd-byte line detection.
module cmos_pixel_capture #(
    parameter int unsigned DW           = 8,
    parameter int unsigned DUMMY_FRAMES = 10,
    parameter int unsigned XW           = 12,
    parameter int unsigned YW           = 12
) (
    input  logic                  cmos_pclk,
    input  logic                  rst,
    cmos_pixel_capture_if.slave   cam
);

    localparam int unsigned CW        = (DUMMY_FRAMES > 0) ? $clog2(DUMMY_FRAMES + 1) : 1;
    localparam logic [CW-1:0] DUMMY_MAX = CW'(DUMMY_FRAMES);
    localparam logic [1:0]    MODE_RAW  = 2'd1;

    typedef enum logic [1:0] {
        WAIT_DUMMY = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              vsync_q, href_q;
    logic [CW-1:0]     dummy_q, dummy_d;
    logic [1:0]        mode_q, mode_d;
    logic              phase_q, phase_d;
    logic [DW-1:0]     hi_q, hi_d;
    logic [XW-1:0]     col_q, col_d;
    logic [YW-1:0]     row_q, row_d;
    logic              line_pix_q, line_pix_d;
    logic              frame_pix_q, frame_pix_d;
    logic [2*DW-1:0]   pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic [XW-1:0]     pix_x_q, pix_x_d;
    logic [YW-1:0]     pix_y_q, pix_y_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_end_q, frame_end_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              line_err_q, line_err_d;

    logic vs_rise, href_fall, capture, raw;

    assign vs_rise   = cam.cmos_vsync & ~vsync_q;
    assign href_fall = ~cam.cmos_href & href_q;
    // A vsync edge wins over a coincident href byte.
    assign capture   = (state_q == ACTIVE) & cam.cmos_href & ~vs_rise;
    assign raw       = (mode_q == MODE_RAW);
    assign dummy_d   = (vs_rise && (dummy_q != DUMMY_MAX)) ? dummy_q + CW'(1) : dummy_q;

    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_DUMMY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_DUMMY: if (dummy_d == DUMMY_MAX)          state_d = WAIT_FRAME;
            WAIT_FRAME: if (vs_rise && cam.enable)         state_d = ACTIVE;
            ACTIVE:     if (vs_rise && !cam.enable)        state_d = WAIT_FRAME;
            default:                                       state_d = WAIT_DUMMY;
        endcase
    end

    always_comb begin
        mode_d        = mode_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        col_d         = col_q;
        row_d         = row_q;
        line_pix_d    = line_pix_q;
        frame_pix_d   = frame_pix_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        line_err_d    = 1'b0;

        if (!cam.cmos_href || (state_q != ACTIVE) || vs_rise) begin
            phase_d = 1'b0;
            col_d   = '0;
        end

        if (capture) begin
            if (!raw && !phase_q) begin
                hi_d    = cam.cmos_d;
                phase_d = 1'b1;
            end else begin
                phase_d       = 1'b0;
                pix_data_d    = raw ? {DW'(0), cam.cmos_d} : {hi_q, cam.cmos_d};
                pix_valid_d   = 1'b1;
                pix_x_d       = col_q;
                pix_y_d       = row_q;
                col_d         = col_q + XW'(1);
                line_pix_d    = 1'b1;
                frame_pix_d   = 1'b1;
                frame_start_d = ~frame_pix_q;
            end
        end

        if (href_fall && (state_q == ACTIVE) && !vs_rise) begin
            if (line_pix_q) row_d = row_q + YW'(1);
            line_pix_d = 1'b0;
            if (!raw && phase_q) line_err_d = 1'b1;
        end

        // Frame boundary: close the running frame and latch the next mode.
        if (vs_rise) begin
            row_d       = '0;
            line_pix_d  = 1'b0;
            frame_pix_d = 1'b0;
            if ((state_q == ACTIVE) && frame_pix_q) begin
                frame_end_d = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            if ((state_q != WAIT_DUMMY) && cam.enable) mode_d = cam.mode;
        end
    end

    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            dummy_q       <= '0;
            mode_q        <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            col_q         <= '0;
            row_q         <= '0;
            line_pix_q    <= 1'b0;
            frame_pix_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_cnt_q   <= '0;
            line_err_q    <= 1'b0;
        end else begin
            vsync_q       <= cam.cmos_vsync;
            href_q        <= cam.cmos_href;
            dummy_q       <= dummy_d;
            mode_q        <= mode_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            col_q         <= col_d;
            row_q         <= row_d;
            line_pix_q    <= line_pix_d;
            frame_pix_q   <= frame_pix_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_cnt_q   <= frame_cnt_d;
            line_err_q    <= line_err_d;
        end
    end

    assign cam.pix_data    = pix_data_q;
    assign cam.pix_valid   = pix_valid_q;
    assign cam.pix_x       = pix_x_q;
    assign cam.pix_y       = pix_y_q;
    assign cam.frame_start = frame_start_q;
    assign cam.frame_end   = frame_end_q;
    assign cam.frame_cnt   = frame_cnt_q;
    assign cam.line_err    = line_err_q;

endmodule
